// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one UART transmitter
// among N_REQ byte requesters. It grants one pending requester, latches its
// byte, pulses tx_start, follows the frame through tx_busy, acknowledges the
// requester and then holds an inter-frame gap before granting again.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,     // number of requesters (2..8)
    parameter int GAP_CYCLES   = 5210,  // idle cycles between frames, 0 = no gap
    parameter int BUSY_TIMEOUT = 16     // cycles allowed for tx_busy to rise
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy,
    output logic [2:0]         grant_id,
    output logic               active,
    output logic               err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       ptr;        // highest-priority requester for the next search
    logic [2:0]       sel_q;      // requester picked in IDLE, consumed in LOAD
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             pick_valid;
    logic [2:0]       pick_idx;
    logic [3:0]       cand;
    logic             grab;
    logic             timeout;
    logic             done;
    logic [7:0]       req_bytes [N_REQ];

    // Unpack the flat data bus into one byte per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign req_bytes[g] = req_data[8*g +: 8];
    end

    // Successor index with wrap from N_REQ-1 back to 0.
    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'(N_REQ - 1)) ? 3'd0 : i + 3'd1;
    endfunction

    // Rotated priority search: the lowest offset from ptr with req set wins.
    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[2:0];
            end
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the single-cycle strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        grab      = 1'b0;
        timeout   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    grab      = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_START;
            end
            S_START: begin
                tx_start  = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                // The first low on tx_busy ends the frame; later glitches are ignored.
                if (!tx_busy) begin
                    done      = 1'b1;
                    state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant capture, byte latch, pointer rotation, ack pulse, error flag, counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            tx_data  <= 8'h00;
            grant_id <= '0;
            ptr      <= '0;
            ack      <= '0;
            err      <= 1'b0;
            tmo_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            if (grab) begin
                sel_q <= pick_idx;
            end
            // The byte is frozen here, so later req_data changes cannot reach the UART.
            if (state == S_LOAD) begin
                tx_data  <= req_bytes[sel_q[IDX_W-1:0]];
                grant_id <= sel_q;
            end
            // A timed-out requester also drops to lowest priority; it keeps req and retries.
            if (timeout || done) begin
                ptr <= next_idx(grant_id);
            end
            if (timeout) begin
                err <= 1'b1;
            end
            ack <= done ? (N_REQ'(1) << grant_id) : '0;
            // Leaving WAIT_BUSY or GAP (including START) clears the counter.
            tmo_cnt <= (state == S_WAIT_BUSY) ? tmo_cnt + 1'b1 : '0;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    assign active = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART Tx responder model.
module tb_uart_tx_arbiter;

    localparam int GAP      = 4;
    localparam int TMO      = 6;
    localparam int BUSY_LEN = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [2:0]  grant_id;
    logic        active;
    logic        err;

    logic        uart_en;
    int          busy_cnt  = 0;
    int          ack_count = 0;
    int          multi_ack = 0;
    int          total     = 0;
    int          bad       = 0;
    int          acks_before;

    uart_tx_arbiter #(
        .N_REQ        (4),
        .GAP_CYCLES   (GAP),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .active   (active),
        .err      (err)
    );

    always #5 clk = ~clk;

    // UART Tx model: busy for BUSY_LEN cycles after each accepted start pulse.
    always @(posedge clk) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (uart_en && tx_start) begin
            busy_cnt <= BUSY_LEN;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt != 0);

    // Ack monitor: counts ack pulses and cycles with more than one ack bit set.
    always @(posedge clk) begin
        if (ack != 4'b0000) ack_count <= ack_count + 1;
        if ($countones(ack) > 1) multi_ack <= multi_ack + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] exp);
        int n = 0;
        tick();
        while (ack == 4'b0000 && n < 200) begin
            tick();
            n++;
        end
        check(tag, ack, exp);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        tick();
        while (tx_start !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, tx_start, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        tick();
        while (active !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, active, 1'b0);
    endtask

    initial begin
        // Reset held two cycles with every requester pending.
        rst      = 1'b1;
        req      = 4'b1111;
        req_data = {8'hD3, 8'hA5, 8'h5A, 8'h0F};
        uart_en  = 1'b1;
        tick();
        check("rst_ack",      ack,      4'b0000);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data",  tx_data,  8'h00);
        check("rst_grant",    grant_id, 3'd0);
        check("rst_active",   active,   1'b0);
        check("rst_err",      err,      1'b0);
        tick();
        check("rst2_tx_start", tx_start, 1'b0);
        check("rst2_active",   active,   1'b0);

        // Round robin from ptr=0: each requester dropped on its ack.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_ack("rr_ack", 4'(1 << i));
            check("rr_grant", grant_id, 3'(i));
            req[i] = 1'b0;
        end
        wait_idle("rr_idle");
        check("rr_ack_total", ack_count, 4);

        // Fairness wrap: req0 and req3 held, grants alternate 0,3,0,3.
        req = 4'b1001;
        wait_ack("fair_ack0", 4'b0001);
        wait_ack("fair_ack1", 4'b1000);
        wait_ack("fair_ack2", 4'b0001);
        wait_ack("fair_ack3", 4'b1000);
        req = 4'b0000;
        wait_idle("fair_idle");

        // Single request, cycle-exact.
        req = 4'b0100;
        tick();
        check("single_load_start", tx_start, 1'b0);
        check("single_load_active", active, 1'b1);
        tick();
        check("single_start",    tx_start, 1'b1);
        check("single_tx_data",  tx_data,  8'hA5);
        check("single_grant",    grant_id, 3'd2);
        req_data[23:16] = 8'h00;
        repeat (6) tick();
        check("single_busy_fell", tx_busy,  1'b0);
        check("single_no_ack_yet", ack,     4'b0000);
        check("single_data_held", tx_data,  8'hA5);
        tick();
        check("single_ack", ack, 4'b0100);
        req = 4'b0000;
        req_data[23:16] = 8'hA5;
        tick();
        check("single_ack_pulse", ack,    4'b0000);
        check("single_gap",       active, 1'b1);
        repeat (2) tick();
        check("single_gap_end",   active, 1'b1);
        tick();
        check("single_idle",      active, 1'b0);

        // Busy timeout: no UART response, err sticks, requester retried.
        uart_en     = 1'b0;
        acks_before = ack_count;
        req         = 4'b0001;
        repeat (8) tick();
        check("tmo_err_early", err,    1'b0);
        check("tmo_waiting",   active, 1'b1);
        tick();
        check("tmo_err",       err,    1'b1);
        check("tmo_idle",      active, 1'b0);
        check("tmo_no_ack",    ack_count, acks_before);
        repeat (2) tick();
        check("tmo_retry",       tx_start, 1'b1);
        check("tmo_retry_grant", grant_id, 3'd0);
        uart_en = 1'b1;
        wait_ack("tmo_retry_ack", 4'b0001);
        req = 4'b0000;
        wait_idle("tmo_retry_idle");
        check("tmo_err_sticky", err, 1'b1);

        // Reset in WAIT_DONE aborts without ack and clears ptr/err.
        req = 4'b0010;
        wait_start("mid_start");
        check("mid_grant", grant_id, 3'd1);
        repeat (2) tick();
        check("mid_tx_data", tx_data, 8'h5A);
        check("mid_busy",    tx_busy, 1'b1);
        acks_before = ack_count;
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        check("mid_active",  active,   1'b0);
        check("mid_tx_data0", tx_data, 8'h00);
        check("mid_grant0",  grant_id, 3'd0);
        check("mid_err0",    err,      1'b0);
        repeat (6) tick();
        check("mid_no_ack",  ack_count, acks_before);
        req = 4'b1001;
        wait_start("mid_ptr_start");
        check("mid_ptr_grant", grant_id, 3'd0);
        wait_ack("mid_ptr_ack", 4'b0001);
        req = 4'b0000;
        wait_idle("mid_final_idle");

        check("onehot_ack", multi_ack, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
